// File: rtl/sram_access_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_access_scheduler_pkg
// Brief   : Shared widths and FSM state encoding for the SRAM access scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package sram_access_scheduler_pkg;

   localparam int c_ADDR_W = 17;
   localparam int c_DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ADDR  = 3'd1,
      ST_RD_DONE  = 3'd2,
      ST_WR_SETUP = 3'd3,
      ST_WR_PULSE = 3'd4,
      ST_WR_HOLD  = 3'd5
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_access_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : sram_access_scheduler_if
// Brief   : Requester-side bundle: capture writer, display reader, frame pulses.
// Revision: 1.0 - initial release
// ============================================================================
interface sram_access_scheduler_if;
   import sram_access_scheduler_pkg::*;

   logic                wr_req;
   logic [c_ADDR_W-1:0] wr_addr;
   logic [c_DATA_W-1:0] wr_data;
   logic                wr_ack;
   logic                rd_req;
   logic [c_ADDR_W-1:0] rd_addr;
   logic                rd_ack;
   logic [c_DATA_W-1:0] rd_data;
   logic                rd_valid;
   logic                frame_start_in;
   logic                frame_start_out;
   logic                wr_bank;
   logic                rd_bank;

   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr,
             frame_start_in, frame_start_out,
      input  wr_ack, rd_ack, rd_data, rd_valid, wr_bank, rd_bank
   );

   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
             frame_start_in, frame_start_out,
      output wr_ack, rd_ack, rd_data, rd_valid, wr_bank, rd_bank
   );

endinterface
`default_nettype wire

// File: rtl/sram_access_scheduler_bank_tracker.sv
`default_nettype none
// ============================================================================
// Module  : sram_access_scheduler_bank_tracker
// Brief   : Double-buffer bank selection for writer and reader.
// Revision: 1.0 - initial release
// ============================================================================
module sram_access_scheduler_bank_tracker (
   input  logic sysClk,
   input  logic reset,
   input  logic frame_start_in,
   input  logic frame_start_out,
   output logic wr_bank,
   output logic rd_bank
);

   logic r_wr_bank;
   logic r_rd_bank;
   logic w_wr_bank_next;

   // Reader takes the bank just completed, including a same-cycle writer swap.
   assign w_wr_bank_next = r_wr_bank ^ frame_start_in;

   always_ff @(posedge sysClk or posedge reset) begin
      if (reset) begin
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b1;
      end else begin
         r_wr_bank <= w_wr_bank_next;
         if (frame_start_out)
            r_rd_bank <= ~w_wr_bank_next;
      end
   end

   assign wr_bank = r_wr_bank;
   assign rd_bank = r_rd_bank;

endmodule
`default_nettype wire

// File: rtl/sram_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : sram_access_scheduler
// Brief   : Arbitrates one framebuffer SRAM between capture writer and display reader.
// Revision: 1.0 - initial release
// ============================================================================
module sram_access_scheduler
   import sram_access_scheduler_pkg::*;
#(
   parameter int WR_PULSE_CYCLES = 2,
   parameter int RD_LATENCY      = 2,
   parameter int WR_STARVE_LIMIT = 4
) (
   input  logic                  sysClk,
   input  logic                  reset,
   sram_access_scheduler_if.slave bus,
   output logic [c_ADDR_W:0]     sram_addr,
   inout  wire  [c_DATA_W-1:0]   sram_data,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n
);

   localparam int c_CNT_MAX = (WR_PULSE_CYCLES > RD_LATENCY) ? WR_PULSE_CYCLES : RD_LATENCY;
   localparam int c_CNT_W   = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX);
   localparam int c_STV_W   = (WR_STARVE_LIMIT < 1) ? 1 : $clog2(WR_STARVE_LIMIT + 1);
   localparam logic [c_CNT_W-1:0] c_RD_LAST = c_CNT_W'(RD_LATENCY - 1);
   localparam logic [c_CNT_W-1:0] c_WR_LAST = c_CNT_W'(WR_PULSE_CYCLES - 1);
   localparam logic [c_STV_W-1:0] c_STV_LIM = c_STV_W'(WR_STARVE_LIMIT);

   sched_state_t r_state;
   sched_state_t w_state_next;
   logic         w_grant_rd;
   logic         w_grant_wr;
   logic         w_rd_last;

   logic [c_CNT_W-1:0]  r_cnt;
   logic [c_STV_W-1:0]  r_starve;
   logic [c_DATA_W-1:0] r_wdata;
   logic [c_DATA_W-1:0] r_rd_data;
   logic [c_ADDR_W:0]   r_sram_addr;
   logic                r_drive;
   logic                r_ce_n;
   logic                r_oe_n;
   logic                r_we_n;
   logic                r_wr_ack;
   logic                r_rd_ack;
   logic                r_rd_valid;
   logic                w_wr_bank;
   logic                w_rd_bank;

   sram_access_scheduler_bank_tracker u_bank_tracker (
      .sysClk          (sysClk),
      .reset           (reset),
      .frame_start_in  (bus.frame_start_in),
      .frame_start_out (bus.frame_start_out),
      .wr_bank         (w_wr_bank),
      .rd_bank         (w_rd_bank)
   );

   always_comb begin
      w_state_next = r_state;
      w_grant_rd   = 1'b0;
      w_grant_wr   = 1'b0;
      w_rd_last    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Reads win ties until the pending writer has been starved long enough.
            if (bus.rd_req && (!bus.wr_req || (r_starve < c_STV_LIM))) begin
               w_grant_rd   = 1'b1;
               w_state_next = ST_RD_ADDR;
            end else if (bus.wr_req) begin
               w_grant_wr   = 1'b1;
               w_state_next = ST_WR_SETUP;
            end
         end
         ST_RD_ADDR: begin
            if (r_cnt == c_RD_LAST) begin
               w_rd_last    = 1'b1;
               w_state_next = ST_RD_DONE;
            end
         end
         ST_RD_DONE:  w_state_next = ST_IDLE;
         ST_WR_SETUP: w_state_next = ST_WR_PULSE;
         ST_WR_PULSE: begin
            if (r_cnt == c_WR_LAST)
               w_state_next = ST_WR_HOLD;
         end
         ST_WR_HOLD:  w_state_next = ST_IDLE;
         default:     w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysClk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= (w_state_next != r_state) ? '0 : r_cnt + c_CNT_W'(1);
      end
   end

   // Strobes are registered from the next state so the pins never glitch.
   always_ff @(posedge sysClk or posedge reset) begin
      if (reset) begin
         r_ce_n     <= 1'b1;
         r_oe_n     <= 1'b1;
         r_we_n     <= 1'b1;
         r_drive    <= 1'b0;
         r_wr_ack   <= 1'b0;
         r_rd_ack   <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_wdata    <= '0;
         r_sram_addr <= '0;
         r_starve   <= '0;
      end else begin
         r_ce_n     <= (w_state_next == ST_IDLE);
         r_oe_n     <= (w_state_next != ST_RD_ADDR);
         r_we_n     <= (w_state_next != ST_WR_PULSE);
         r_drive    <= (w_state_next == ST_WR_SETUP) || (w_state_next == ST_WR_PULSE) ||
                       (w_state_next == ST_WR_HOLD);
         r_wr_ack   <= w_grant_wr;
         r_rd_ack   <= w_grant_rd;
         r_rd_valid <= w_rd_last;
         if (w_rd_last)
            r_rd_data <= sram_data;
         if (w_grant_rd)
            r_sram_addr <= {w_rd_bank, bus.rd_addr};
         if (w_grant_wr) begin
            r_sram_addr <= {w_wr_bank, bus.wr_addr};
            r_wdata     <= bus.wr_data;
         end
         if (w_grant_wr)
            r_starve <= '0;
         else if (w_grant_rd && bus.wr_req && (r_starve < c_STV_LIM))
            r_starve <= r_starve + c_STV_W'(1);
      end
   end

   assign sram_data = r_drive ? r_wdata : {c_DATA_W{1'bz}};
   assign sram_addr = r_sram_addr;
   assign sram_ce_n = r_ce_n;
   assign sram_oe_n = r_oe_n;
   assign sram_we_n = r_we_n;

   assign bus.wr_ack   = r_wr_ack;
   assign bus.rd_ack   = r_rd_ack;
   assign bus.rd_data  = r_rd_data;
   assign bus.rd_valid = r_rd_valid;
   assign bus.wr_bank  = w_wr_bank;
   assign bus.rd_bank  = w_rd_bank;

endmodule
`default_nettype wire

// File: tb/tb_sram_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_access_scheduler
// Brief   : Directed/randomized bench with SRAM model and reference scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_access_scheduler;

   logic        sysClk = 1'b0;
   logic        reset  = 1'b1;
   wire  [15:0] sram_data;
   logic [17:0] sram_addr;
   logic        sram_ce_n, sram_oe_n, sram_we_n;

   sram_access_scheduler_if bus ();

   sram_access_scheduler #(
      .WR_PULSE_CYCLES (2),
      .RD_LATENCY      (2),
      .WR_STARVE_LIMIT (4)
   ) dut (
      .sysClk    (sysClk),
      .reset     (reset),
      .bus       (bus.slave),
      .sram_addr (sram_addr),
      .sram_data (sram_data),
      .sram_ce_n (sram_ce_n),
      .sram_oe_n (sram_oe_n),
      .sram_we_n (sram_we_n)
   );

   always #5 sysClk = ~sysClk;

   // Asynchronous SRAM model with a preload port for the bench
   logic [15:0] mem [0:262143];
   logic        pl_en = 1'b0;
   logic [17:0] pl_addr = '0;
   logic [15:0] pl_data = '0;

   assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hzzzz;

   always @(posedge sysClk) begin
      if (pl_en)
         mem[pl_addr] <= pl_data;
      else if (!sram_ce_n && !sram_we_n)
         mem[sram_addr] <= sram_data;
   end

   int          checks = 0;
   int          errors = 0;
   logic        mwr, mrd;
   logic [15:0] ref_mem [logic [17:0]];

   task automatic step();
      @(posedge sysClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.wr_req = 1'b0; bus.rd_req = 1'b0;
      bus.frame_start_in = 1'b0; bus.frame_start_out = 1'b0;
      step(); step();
      reset = 1'b0;
      step();
      mwr = 1'b0; mrd = 1'b1;
   endtask

   task automatic preload(input logic [17:0] a, input logic [15:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      step();
      pl_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (!sram_ce_n && n < 20) begin
         step();
         n++;
      end
      chk(tag, sram_ce_n, 1'b1);
   endtask

   task automatic do_read(input string tag, input logic [16:0] a);
      logic [15:0] exp_d;
      exp_d = ref_mem[{mrd, a}];
      bus.rd_addr = a; bus.rd_req = 1'b1;
      step();                                   // T+1
      chk({tag, "_ack"}, bus.rd_ack, 1'b1);
      chk({tag, "_oe1"}, sram_oe_n, 1'b0);
      chk({tag, "_addr"}, sram_addr, {mrd, a});
      bus.rd_req = 1'b0;
      step();                                   // T+2
      chk({tag, "_oe2"}, {bus.rd_ack, sram_oe_n}, 2'b00);
      step();                                   // T+3
      chk({tag, "_valid"}, {bus.rd_valid, sram_oe_n, sram_ce_n}, 3'b110);
      chk({tag, "_data"}, bus.rd_data, exp_d);
      step();                                   // T+4
      chk({tag, "_end"}, {sram_ce_n, bus.rd_valid}, 2'b10);
   endtask

   task automatic bank_pulse(input logic fin, input logic fout);
      logic nxt;
      bus.frame_start_in = fin; bus.frame_start_out = fout;
      step();
      bus.frame_start_in = 1'b0; bus.frame_start_out = 1'b0;
      nxt = mwr ^ fin;
      if (fout) mrd = ~nxt;
      mwr = nxt;
      chk("wr_bank", bus.wr_bank, mwr);
      chk("rd_bank", bus.rd_bank, mrd);
   endtask

   initial begin : main
      int          n, n_low, grants, drain;
      logic        exp_w;
      logic [16:0] a1, a2;
      logic [15:0] d1, d2;
      logic [15:0] exp_rd [$];
      logic [17:0] wkeys [$];

      bus.wr_req = 1'b0; bus.rd_req = 1'b0;
      bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
      bus.frame_start_in = 1'b0; bus.frame_start_out = 1'b0;
      do_reset();

      // Reset state
      chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
      chk("rst_acks", {bus.wr_ack, bus.rd_ack, bus.rd_valid}, 3'b000);
      chk("rst_rd_data", bus.rd_data, 16'h0);
      chk("rst_banks", {bus.wr_bank, bus.rd_bank}, 2'b01);
      chk("rst_addr", sram_addr, 18'h0);

      // Read-only access
      preload(18'h20010, 16'hA5A5);
      do_read("rd1", 17'h00010);

      // Write-only access
      bus.wr_addr = 17'h1FFFF; bus.wr_data = 16'h1234; bus.wr_req = 1'b1;
      step();
      chk("wr_ack", bus.wr_ack, 1'b1);
      chk("wr_setup", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b011);
      chk("wr_drive", sram_data, 16'h1234);
      bus.wr_req = 1'b0;
      n = 0; n_low = 0;
      while (!sram_ce_n && n < 20) begin
         if (!sram_we_n) n_low++;
         step();
         n++;
      end
      chk("wr_we_low", n_low, 2);
      chk("wr_len", n, 4);
      chk("wr_mem", mem[18'h1FFFF], 16'h1234);

      // Continuous contention: 4 reads then 1 write, repeating
      do_reset();
      for (int i = 0; i < 16; i++) preload({1'b1, 17'(i)}, 16'($urandom));
      bus.rd_addr = 17'($urandom_range(0, 15));
      bus.wr_addr = 17'($urandom); bus.wr_data = 16'($urandom);
      bus.rd_req = 1'b1; bus.wr_req = 1'b1;
      grants = 0; drain = 0; n = 0;
      while (n < 400 && drain < 8) begin
         step();
         n++;
         if (bus.rd_ack || bus.wr_ack) begin
            exp_w = ((grants % 5) == 4);
            chk("grant_is_write", {bus.wr_ack, bus.rd_ack}, {exp_w, ~exp_w});
            if (bus.rd_ack) begin
               exp_rd.push_back(ref_mem[{mrd, bus.rd_addr}]);
               bus.rd_addr = 17'($urandom_range(0, 15));
            end
            if (bus.wr_ack) begin
               ref_mem[{mwr, bus.wr_addr}] = bus.wr_data;
               wkeys.push_back({mwr, bus.wr_addr});
               bus.wr_addr = 17'($urandom); bus.wr_data = 16'($urandom);
            end
            grants++;
            if (grants == 10) begin
               bus.rd_req = 1'b0; bus.wr_req = 1'b0;
            end
         end
         if (bus.rd_valid) begin
            if (exp_rd.size() > 0) chk("mix_rd_data", bus.rd_data, exp_rd.pop_front());
            else chk("mix_spurious_valid", bus.rd_valid, 1'b0);
         end
         if (grants >= 10) drain++;
      end
      chk("mix_grants", grants, 10);
      chk("mix_rd_pending", exp_rd.size(), 0);
      foreach (wkeys[k]) chk("mix_wr_mem", mem[wkeys[k]], ref_mem[wkeys[k]]);

      // Bank swaps, sequential then simultaneous
      do_reset();
      bank_pulse(1'b1, 1'b0);
      bank_pulse(1'b0, 1'b1);
      do_reset();
      bank_pulse(1'b1, 1'b1);

      // Swap during a write pulse does not disturb the in-flight access
      do_reset();
      a1 = 17'($urandom); d1 = 16'($urandom);
      a2 = 17'($urandom); d2 = 16'($urandom);
      bus.wr_addr = a1; bus.wr_data = d1; bus.wr_req = 1'b1;
      step();
      bus.wr_req = 1'b0;
      step();
      chk("sw_in_pulse", sram_we_n, 1'b0);
      bank_pulse(1'b1, 1'b0);
      chk("sw_addr_pulse", sram_addr[17], 1'b0);
      step();
      chk("sw_addr_hold", sram_addr[17], 1'b0);
      wait_idle("sw_idle1");
      bus.wr_addr = a2; bus.wr_data = d2; bus.wr_req = 1'b1;
      step();
      chk("sw_new_bank", sram_addr, {mwr, a2});
      bus.wr_req = 1'b0;
      wait_idle("sw_idle2");
      chk("sw_mem_old", mem[{1'b0, a1}], d1);
      chk("sw_mem_new", mem[{1'b1, a2}], d2);

      // Reset mid write pulse
      do_reset();
      bus.wr_addr = 17'($urandom); bus.wr_data = 16'($urandom); bus.wr_req = 1'b1;
      step();
      bus.wr_req = 1'b0;
      step();
      chk("rs_in_pulse", sram_we_n, 1'b0);
      reset = 1'b1;
      #1;
      chk("rs_strobes", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b111);
      chk("rs_no_ack", {bus.wr_ack, bus.rd_valid}, 2'b00);
      step(); step();
      reset = 1'b0;
      mwr = 1'b0; mrd = 1'b1;
      step();
      chk("rs_after", {sram_ce_n, bus.wr_ack, bus.rd_valid}, 3'b100);
      do_read("rd2", 17'h00010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
